// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams instruction words into the instruction memory
// as MSB-first cells at consecutive addresses.
module instr_mem_loader #(
  parameter int WORD_LEN       = 16,
  parameter int MEM_CELL_LEN   = 4,
  parameter int INSTR_MEM_SIZE = 64,
  localparam int ADDR_W        = $clog2(INSTR_MEM_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic                    in_valid,
  input  logic [WORD_LEN-1:0]     in_word,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [MEM_CELL_LEN-1:0] mem_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_W-1:0]       word_count
);

  localparam int CELLS = WORD_LEN / MEM_CELL_LEN;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [ADDR_W:0] SIZE_X  = (ADDR_W+1)'(INSTR_MEM_SIZE);
  localparam logic [ADDR_W:0] CELLS_X = (ADDR_W+1)'(CELLS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

  typedef enum logic [1:0] {
    IDLE, WAIT_WORD, WRITE, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]        idx_q, idx_d, nxt_idx;
  logic [WORD_LEN-1:0]     word_q, word_d;
  logic                    last_q, last_d;
  logic                    fits;
  logic                    ready_d, we_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]       addr_d, wc_d;
  logic [MEM_CELL_LEN-1:0] data_d;

  function automatic logic [MEM_CELL_LEN-1:0] cell_of(
    input logic [WORD_LEN-1:0] w,
    input logic [IDX_W-1:0]    i
  );
    cell_of = w[WORD_LEN-1-int'(i)*MEM_CELL_LEN -: MEM_CELL_LEN];
  endfunction

  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    ready_d = 1'b0;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    data_d  = mem_data;
    done_d  = 1'b0;
    err_d   = err;
    wc_d    = word_count;
    nxt_idx = idx_q + 1'b1;
    fits    = ({1'b0, ptr_q} + CELLS_X) <= SIZE_X;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = start_addr;
          err_d   = 1'b0;
          wc_d    = '0;
          ready_d = 1'b1;
          state_d = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        ready_d = 1'b1;
        if (in_valid && in_ready) begin
          ready_d = 1'b0;
          if (!fits) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = '0;
            word_d  = in_word;
            last_d  = in_last;
            we_d    = 1'b1;
            addr_d  = ptr_q;
            data_d  = cell_of(in_word, '0);
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (idx_q == IDX_LAST) begin
          ptr_d = ptr_q + ADDR_W'(CELLS);
          wc_d  = word_count + 1'b1;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            ready_d = 1'b1;
            state_d = WAIT_WORD;
          end
        end else begin
          idx_d  = nxt_idx;
          we_d   = 1'b1;
          addr_d = ptr_q + ADDR_W'(nxt_idx);
          data_d = cell_of(word_q, nxt_idx);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      in_ready   <= ready_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_data   <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      word_count <= wc_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed sessions with a write scoreboard
// checked by an independent monitor on the falling edge.
module tb_instr_mem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          in_valid;
  logic [15:0]   in_word;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] word_count;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;
  int w     = 0;
  logic [9:0] sb[$];

  instr_mem_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .start_addr(start_addr), .in_valid(in_valid),
    .in_word(in_word), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none",
                 mem_addr, mem_data);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("wr_addr", int'(mem_addr), int'(e[9:4]));
        chk("wr_data", int'(mem_data), int'(e[3:0]));
      end
    end
  end

  task automatic do_start(input int a);
    @(negedge clk);
    start = 1'b1;
    start_addr = AW'(a);
    @(negedge clk);
    start = 1'b0;
    mptr = a;
    chk("st_busy", int'(busy), 1);
    chk("st_ready", int'(in_ready), 1);
    chk("st_err", int'(err), 0);
    chk("st_wc", int'(word_count), 0);
  endtask

  task automatic send_word(input logic [15:0] wd, input bit last,
                           input int ncells, output int waits);
    @(negedge clk);
    in_valid = 1'b1;
    in_word = wd;
    in_last = last;
    waits = 0;
    while (in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (in_ready !== 1'b1) chk("ready_timeout", 0, 1);
    if (mptr + 4 <= 64) begin
      for (int i = 0; i < ncells; i++)
        sb.push_back({AW'(mptr + i), wd[15-4*i -: 4]});
      mptr += 4;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input int lat, input int wc, input int er);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
    if (lat >= 0) chk("done_lat", n, lat);
    chk("done_busy", int'(busy), 1);
    chk("done_wc", int'(word_count), wc);
    chk("done_err", int'(err), er);
    chk("sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_wc", int'(word_count), wc);
    chk("idle_err", int'(err), er);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, int'(in_ready), 0);
    chk({nm, "_we"}, int'(mem_we), 0);
    chk({nm, "_addr"}, int'(mem_addr), 0);
    chk({nm, "_data"}, int'(mem_data), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_wc"}, int'(word_count), 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    start_addr = '0;
    in_valid = 1'b0;
    in_word = '0;
    in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");

    // single word, exact cell order
    do_start(8);
    send_word(16'h3010, 1'b1, 4, w);
    wait_done(4, 1, 0);

    // back-to-back words with in_valid effectively held
    do_start(8);
    send_word(16'h3010, 1'b0, 4, w);
    chk("w1_wait", w, 0);
    send_word(16'h3020, 1'b0, 4, w);
    chk("w2_wait", w, 4);
    send_word(16'hC311, 1'b1, 4, w);
    chk("w3_wait", w, 4);
    wait_done(4, 3, 0);

    // gapped words: no writes while waiting
    do_start(8);
    send_word(16'h3010, 1'b0, 4, w);
    repeat (11) @(negedge clk);
    chk("gap_ready", int'(in_ready), 1);
    chk("gap_busy", int'(busy), 1);
    send_word(16'h3020, 1'b0, 4, w);
    repeat (11) @(negedge clk);
    send_word(16'hC311, 1'b1, 4, w);
    wait_done(4, 3, 0);

    // exact fit at the top of memory, then overflow
    do_start(60);
    send_word(16'hABCD, 1'b1, 4, w);
    wait_done(4, 1, 0);
    do_start(62);
    send_word(16'h1234, 1'b1, 4, w);
    wait_done(0, 0, 1);
    do_start(0);
    send_word(16'h5A5A, 1'b1, 4, w);
    wait_done(4, 1, 0);

    // reset during the second cell of a word
    do_start(20);
    send_word(16'h9876, 1'b1, 2, w);
    @(negedge clk);
    @(negedge clk);
    chk("mid_we", int'(mem_we), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_zero("midrst");
    chk("midrst_sb", sb.size(), 0);
    do_start(0);
    send_word(16'h0F1E, 1'b1, 4, w);
    wait_done(4, 1, 0);

    // start while writing is ignored
    do_start(32);
    send_word(16'h4321, 1'b0, 4, w);
    @(negedge clk);
    start = 1'b1;
    start_addr = AW'(40);
    @(negedge clk);
    start = 1'b0;
    chk("st6_wc", int'(word_count), 0);
    send_word(16'h8765, 1'b1, 4, w);
    wait_done(4, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
